alu_driver: RTL and testbench

- Sequential initiator for the 5-bit signed combinational ALU (Func encoding: 000 add, 001 sub, 010 not A, 011 and, 100 or, 101 xor, 110 A<B signed, 111 A==B).
- Accepts operation requests on a valid/ready port, drives registered operands and Func to an external ALU instance, holds them for a settle window, samples result and flags, and returns them on a valid/ready response port.
- Keeps an accumulator for chained operations, a sticky overflow flag and an operation counter. Sits between the NPC test/control logic and the ALU.

---
 rtl/alu_driver.sv | 172 +++++++++++++++++
 tb/tb_alu_driver.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_driver.sv
// Sequential initiator for the 5-bit signed ALU: accepts a request, holds registered
// operands on the ALU for a settle window, captures the result and returns it.
module alu_driver #(
  parameter int WIDTH         = 5,
  parameter int CNT_W         = 8,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_func,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic             req_chain,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_func,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_zero,
  input  logic             alu_overflow,
  input  logic             alu_carry,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_out,
  output logic             rsp_zero,
  output logic             rsp_overflow,
  output logic             rsp_carry,
  output logic [WIDTH-1:0] acc,
  output logic             sticky_ovf,
  input  logic             clr_sticky,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam int SCW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SCW-1:0] SETTLE_LOAD = SCW'(SETTLE_CYCLES - 1);

  state_t         state_r;
  state_t         stateNext_s;
  logic [SCW-1:0] settleCnt_r;
  logic           accept_s;
  logic           capture_s;
  logic           isCompare_s;

  // Next-state decode and the accept/capture strobes
  always_comb begin
    stateNext_s = state_r;
    accept_s    = 1'b0;
    capture_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_valid) begin
          accept_s    = 1'b1;
          stateNext_s = SETTLE;
        end else begin
          stateNext_s = IDLE;
        end
      end
      SETTLE: begin
        if (settleCnt_r == {SCW{1'b0}}) begin
          capture_s   = 1'b1;
          stateNext_s = RESP;
        end else begin
          stateNext_s = SETTLE;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          stateNext_s = IDLE;
        end else begin
          stateNext_s = RESP;
        end
      end
      default: begin
        stateNext_s = IDLE;
      end
    endcase
  end

  // Compare functions (110, 111) leave the accumulator untouched
  always_comb begin
    isCompare_s = 1'b0;
    if (alu_func[2:1] == 2'b11) begin
      isCompare_s = 1'b1;
    end else begin
      isCompare_s = 1'b0;
    end
  end

  // State register with handshake flags registered from the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
    end else begin
      state_r   <= stateNext_s;
      req_ready <= (stateNext_s == IDLE);
      rsp_valid <= (stateNext_s == RESP);
    end
  end

  // Settle window counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      settleCnt_r <= {SCW{1'b0}};
    end else if (accept_s) begin
      settleCnt_r <= SETTLE_LOAD;
    end else if ((state_r == SETTLE) && (settleCnt_r != {SCW{1'b0}})) begin
      settleCnt_r <= settleCnt_r - {{(SCW-1){1'b0}}, 1'b1};
    end
  end

  // Operand registers toward the ALU, changed only at request acceptance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a    <= {WIDTH{1'b0}};
      alu_b    <= {WIDTH{1'b0}};
      alu_func <= 3'b000;
    end else if (accept_s) begin
      alu_a    <= req_chain ? acc : req_a;
      alu_b    <= req_b;
      alu_func <= req_func;
    end
  end

  // Response capture at the end of the settle window
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_out      <= {WIDTH{1'b0}};
      rsp_zero     <= 1'b0;
      rsp_overflow <= 1'b0;
      rsp_carry    <= 1'b0;
    end else if (capture_s) begin
      rsp_out      <= alu_out;
      rsp_zero     <= alu_zero;
      rsp_overflow <= alu_overflow;
      rsp_carry    <= alu_carry;
    end
  end

  // Accumulator and operation counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc      <= {WIDTH{1'b0}};
      op_count <= {CNT_W{1'b0}};
    end else if (capture_s) begin
      op_count <= op_count + {{(CNT_W-1){1'b0}}, 1'b1};
      if (!isCompare_s) begin
        acc <= alu_out;
      end
    end
  end

  // Sticky overflow: a capturing overflow beats a simultaneous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_ovf <= 1'b0;
    end else if (capture_s && alu_overflow) begin
      sticky_ovf <= 1'b1;
    end else if (clr_sticky) begin
      sticky_ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_driver.sv
// Directed bench for alu_driver: behavioural ALU model on the alu_* side and a
// scoreboard queue of expected responses filled at request time.
module tb_alu_driver;

  localparam int WIDTH  = 5;
  localparam int CNT_W  = 8;
  localparam int SETTLE = 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid, req_ready, req_chain;
  logic [2:0]       req_func;
  logic [WIDTH-1:0] req_a, req_b;
  logic [WIDTH-1:0] alu_a, alu_b, alu_out;
  logic [2:0]       alu_func;
  logic             alu_zero, alu_overflow, alu_carry;
  logic             rsp_valid, rsp_ready;
  logic [WIDTH-1:0] rsp_out;
  logic             rsp_zero, rsp_overflow, rsp_carry;
  logic [WIDTH-1:0] acc;
  logic             sticky_ovf, clr_sticky;
  logic [CNT_W-1:0] op_count;

  typedef struct packed {
    logic [4:0] res;
    logic       zero;
    logic       ovf;
    logic       carry;
    logic [4:0] accv;
    logic       sticky;
    logic [7:0] cnt;
  } exp_t;

  exp_t       sbQueue[$];
  int         checks = 0;
  int         errors = 0;
  logic [4:0] accModel = 5'd0;
  logic       stickyModel = 1'b0;
  logic [7:0] cntModel = 8'd0;
  logic [7:0] aluRes;

  alu_driver #(.WIDTH(WIDTH), .CNT_W(CNT_W), .SETTLE_CYCLES(SETTLE)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_func(req_func),
    .req_a(req_a), .req_b(req_b), .req_chain(req_chain),
    .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func),
    .alu_out(alu_out), .alu_zero(alu_zero), .alu_overflow(alu_overflow), .alu_carry(alu_carry),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_out(rsp_out),
    .rsp_zero(rsp_zero), .rsp_overflow(rsp_overflow), .rsp_carry(rsp_carry),
    .acc(acc), .sticky_ovf(sticky_ovf), .clr_sticky(clr_sticky), .op_count(op_count)
  );

  always #5 clk = ~clk;

  // Reference ALU: returns {out, zero, overflow, carry}
  function automatic logic [7:0] aluModel(input logic [2:0] f, input logic [4:0] a, input logic [4:0] b);
    logic [5:0] s;
    logic [4:0] o;
    logic       ov;
    logic       cy;
    s  = 6'd0;
    ov = 1'b0;
    cy = 1'b0;
    case (f)
      3'b000: begin
        s  = {1'b0, a} + {1'b0, b};
        o  = s[4:0];
        cy = s[5];
        ov = (a[4] == b[4]) && (o[4] != a[4]);
      end
      3'b001: begin
        s  = {1'b0, a} + {1'b0, ~b} + 6'd1;
        o  = s[4:0];
        cy = s[5];
        ov = (a[4] != b[4]) && (o[4] != a[4]);
      end
      3'b010:  o = ~a;
      3'b011:  o = a & b;
      3'b100:  o = a | b;
      3'b101:  o = a ^ b;
      3'b110:  o = ($signed(a) < $signed(b)) ? 5'd1 : 5'd0;
      default: o = (a == b) ? 5'd1 : 5'd0;
    endcase
    return {o, (o == 5'd0), ov, cy};
  endfunction

  always_comb aluRes = aluModel(alu_func, alu_a, alu_b);
  assign alu_out      = aluRes[7:3];
  assign alu_zero     = aluRes[2];
  assign alu_overflow = aluRes[1];
  assign alu_carry    = aluRes[0];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One operation: drive, push expectation, await response, optional backpressure, handshake
  task automatic doOp(input logic [2:0] f, input logic [4:0] a, input logic [4:0] b,
                      input logic ch, input int hold, input logic clrCap);
    int         w;
    int         lat;
    bit         seen;
    logic [4:0] opA;
    logic [7:0] r;
    exp_t       e;
    w = 0;
    while (!req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("req_ready_before_op", {31'd0, req_ready}, 32'd1);
    opA = ch ? accModel : a;
    r   = aluModel(f, opA, b);
    cntModel = cntModel + 8'd1;
    if (f[2:1] != 2'b11) accModel = r[7:3];
    if (r[1]) stickyModel = 1'b1;
    else if (clrCap) stickyModel = 1'b0;
    sbQueue.push_back('{r[7:3], r[2], r[1], r[0], accModel, stickyModel, cntModel});
    req_valid = 1'b1;
    req_func  = f;
    req_a     = a;
    req_b     = b;
    req_chain = ch;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_a     = 5'($urandom);
    req_b     = 5'($urandom);
    req_func  = 3'($urandom);
    req_chain = 1'b0;
    if (clrCap) clr_sticky = 1'b1;
    lat  = 0;
    seen = 1'b0;
    while (lat < 20 && !seen) begin
      @(negedge clk);
      lat++;
      if (rsp_valid) seen = 1'b1;
    end
    clr_sticky = 1'b0;
    check("rsp_latency", lat, SETTLE + 1);
    check("alu_a_operand", {27'd0, alu_a}, {27'd0, opA});
    if (sbQueue.size() == 0) begin
      check("scoreboard_nonempty", 32'd0, 32'd1);
    end else begin
      e = sbQueue.pop_front();
      check("rsp_out", {27'd0, rsp_out}, {27'd0, e.res});
      check("rsp_zero", {31'd0, rsp_zero}, {31'd0, e.zero});
      check("rsp_overflow", {31'd0, rsp_overflow}, {31'd0, e.ovf});
      check("rsp_carry", {31'd0, rsp_carry}, {31'd0, e.carry});
      check("acc", {27'd0, acc}, {27'd0, e.accv});
      check("sticky_ovf", {31'd0, sticky_ovf}, {31'd0, e.sticky});
      check("op_count", {24'd0, op_count}, {24'd0, e.cnt});
      for (int i = 0; i < hold; i++) begin
        req_valid = 1'b1;
        req_a     = 5'd31;
        req_b     = 5'd31;
        req_func  = 3'b011;
        @(negedge clk);
        check("hold_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("hold_rsp_out", {27'd0, rsp_out}, {27'd0, e.res});
        check("hold_req_ready", {31'd0, req_ready}, 32'd0);
      end
      req_valid = 1'b0;
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    check("post_hs_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("post_hs_req_ready", {31'd0, req_ready}, 32'd1);
    check("alu_a_unchanged", {27'd0, alu_a}, {27'd0, opA});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    bit seenRsp;
    rst = 1'b1; req_valid = 1'b0; req_func = 3'b000; req_a = 5'd0; req_b = 5'd0;
    req_chain = 1'b0; rsp_ready = 1'b0; clr_sticky = 1'b0;
    #1;
    check("reset_req_ready", {31'd0, req_ready}, 32'd1);
    check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("reset_acc", {27'd0, acc}, 32'd0);
    check("reset_op_count", {24'd0, op_count}, 32'd0);
    check("reset_alu_a", {27'd0, alu_a}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    doOp(3'b000, 5'b00111, 5'b01001, 1'b0, 0, 1'b0);   // add with overflow
    doOp(3'b000, 5'b00101, 5'b00011, 1'b0, 0, 1'b0);   // 5+3 = 8
    doOp(3'b110, 5'b11101, 5'b00010, 1'b0, 0, 1'b0);   // -3 < 2, acc kept
    doOp(3'b001, 5'b10101, 5'b01000, 1'b1, 0, 1'b0);   // chain: acc-8 = 0
    doOp(3'b010, 5'b01010, 5'b00000, 1'b0, 0, 1'b0);   // not A
    doOp(3'b101, 5'b10101, 5'b01111, 1'b0, 5, 1'b0);   // xor with backpressure
    doOp(3'b111, 5'b00110, 5'b00110, 1'b0, 0, 1'b0);   // equal

    clr_sticky = 1'b1;
    @(posedge clk);
    #1;
    clr_sticky  = 1'b0;
    stickyModel = 1'b0;
    check("clr_sticky_alone", {31'd0, sticky_ovf}, 32'd0);
    @(negedge clk);

    doOp(3'b000, 5'b00111, 5'b01001, 1'b0, 0, 1'b1);   // clear collides with overflow capture

    req_valid = 1'b1; req_func = 3'b000; req_a = 5'd3; req_b = 5'd4; req_chain = 1'b0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("midop_req_ready", {31'd0, req_ready}, 32'd1);
    check("midop_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("midop_acc", {27'd0, acc}, 32'd0);
    check("midop_op_count", {24'd0, op_count}, 32'd0);
    check("midop_sticky", {31'd0, sticky_ovf}, 32'd0);
    accModel = 5'd0; cntModel = 8'd0; stickyModel = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    rsp_ready = 1'b1;
    seenRsp = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (rsp_valid) seenRsp = 1'b1;
    end
    rsp_ready = 1'b0;
    check("dropped_op_no_rsp", {31'd0, seenRsp}, 32'd0);

    doOp(3'b000, 5'b11111, 5'b00011, 1'b1, 0, 1'b0);   // chain from acc=0

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
